// File: rtl/dfa_flow_sched.sv
// Time-shares one DFA engine across NUM_FLOWS packet flows by saving and
// restoring each flow's engine state around every packet.
module dfa_flow_sched #(
  parameter int NUM_FLOWS = 16,
  parameter int FLOW_W    = 4,
  parameter int STATE_W   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pkt_vld,
  output logic               pkt_rdy,
  input  logic [7:0]         pkt_char,
  input  logic               pkt_sof,
  input  logic               pkt_eof,
  input  logic [FLOW_W-1:0]  pkt_flow,
  output logic [7:0]         eng_char,
  output logic               eng_char_vld,
  output logic [STATE_W-1:0] eng_state_in,
  output logic               eng_state_in_vld,
  input  logic [STATE_W-1:0] eng_state_out,
  input  logic               eng_accept,
  input  logic               flow_clr,
  input  logic [FLOW_W-1:0]  flow_clr_id,
  output logic               match_vld,
  output logic [FLOW_W-1:0]  match_flow,
  output logic [15:0]        match_ofs,
  output logic               drop_err
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, SAVE} state_t;

  state_t              state, state_nxt;
  logic [STATE_W-1:0]  ctx_tbl [NUM_FLOWS];
  logic [FLOW_W-1:0]   flow;
  logic [15:0]         ofs;
  logic                first;
  logic                new_sof;

  // A sof seen after the first beat means the previous packet was truncated.
  assign new_sof = pkt_vld && pkt_sof && !first;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (pkt_vld && pkt_sof) state_nxt = LOAD;
      LOAD:   state_nxt = STREAM;
      STREAM: if (new_sof || (pkt_vld && pkt_eof)) state_nxt = SAVE;
      SAVE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pkt_rdy          = 1'b0;
    eng_char_vld     = 1'b0;
    eng_state_in_vld = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:   pkt_rdy = !(pkt_vld && pkt_sof);
        LOAD:   eng_state_in_vld = 1'b1;
        STREAM: begin
          pkt_rdy      = !new_sof;
          eng_char_vld = pkt_vld && !new_sof;
        end
        default: ;
      endcase
    end
  end

  assign eng_char     = pkt_char;
  assign eng_state_in = ctx_tbl[flow];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flow       <= '0;
      ofs        <= '0;
      first      <= 1'b0;
      match_vld  <= 1'b0;
      match_flow <= '0;
      match_ofs  <= '0;
      drop_err   <= 1'b0;
      for (int i = 0; i < NUM_FLOWS; i++) ctx_tbl[i] <= '0;
    end else begin
      drop_err  <= (state == IDLE) && pkt_vld && !pkt_sof;
      match_vld <= eng_char_vld && eng_accept;
      if (eng_char_vld && eng_accept) begin
        match_flow <= flow;
        match_ofs  <= ofs;
      end
      if (state == IDLE && pkt_vld && pkt_sof) flow <= pkt_flow;
      if (state == LOAD) begin
        ofs   <= '0;
        first <= 1'b1;
      end
      if (eng_char_vld) begin
        first <= 1'b0;
        if (ofs != 16'hFFFF) ofs <= ofs + 16'd1;
      end
      if (state == SAVE) ctx_tbl[flow] <= eng_state_out;
      // Written last so a clear beats a same-cycle save to the same flow.
      if (flow_clr) ctx_tbl[flow_clr_id] <= '0;
    end
  end

endmodule

// File: tb/tb_dfa_flow_sched.sv
// Scoreboard bench for dfa_flow_sched: a toy engine, a per-flow context model
// and a negedge monitor that pops expected engine/match/drop events.
module tb_dfa_flow_sched;
  localparam int NF = 16;
  localparam int FW = 4;
  localparam int SW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pkt_vld, pkt_rdy, pkt_sof, pkt_eof;
  logic [7:0]    pkt_char;
  logic [FW-1:0] pkt_flow;
  logic [7:0]    eng_char;
  logic          eng_char_vld, eng_state_in_vld, eng_accept;
  logic [SW-1:0] eng_state_in, eng_state_out;
  logic          flow_clr;
  logic [FW-1:0] flow_clr_id;
  logic          match_vld, drop_err;
  logic [FW-1:0] match_flow;
  logic [15:0]   match_ofs;

  always #5 clk = ~clk;

  dfa_flow_sched #(.NUM_FLOWS(NF), .FLOW_W(FW), .STATE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
    .pkt_char(pkt_char), .pkt_sof(pkt_sof), .pkt_eof(pkt_eof), .pkt_flow(pkt_flow),
    .eng_char(eng_char), .eng_char_vld(eng_char_vld), .eng_state_in(eng_state_in),
    .eng_state_in_vld(eng_state_in_vld), .eng_state_out(eng_state_out),
    .eng_accept(eng_accept), .flow_clr(flow_clr), .flow_clr_id(flow_clr_id),
    .match_vld(match_vld), .match_flow(match_flow), .match_ofs(match_ofs),
    .drop_err(drop_err)
  );

  // Toy DFA engine: state hashes each byte, '*' is a match.
  function automatic logic [SW-1:0] eng_step(input logic [SW-1:0] s, input logic [7:0] c);
    int t;
    t = int'(s) * 5 + int'(c) + 1;
    return t[SW-1:0];
  endfunction

  logic [SW-1:0] eng_st = '0;
  always @(posedge clk) begin
    if (eng_state_in_vld) eng_st <= eng_state_in;
    else if (eng_char_vld) eng_st <= eng_step(eng_st, eng_char);
  end
  assign eng_state_out = eng_st;
  assign eng_accept    = eng_char_vld && (eng_char == 8'h2A);

  typedef struct { logic [FW-1:0] f; logic [15:0] o; } match_t;

  logic [SW-1:0] mdl_tbl [NF];
  logic [SW-1:0] load_q [$];
  logic [7:0]    char_q [$];
  match_t        match_q [$];
  int            drop_pend = 0;
  bit            pend_active = 0;
  logic [FW-1:0] pend_flow;
  logic [SW-1:0] pend_st;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_state_in_vld || eng_char_vld)
        chk("vld_mutex", int'(eng_state_in_vld && eng_char_vld), 0);
      if (eng_state_in_vld) begin
        if (load_q.size() == 0) chk("load_unexpected", 1, 0);
        else chk("load_state", int'(eng_state_in), int'(load_q.pop_front()));
      end
      if (eng_char_vld) begin
        if (char_q.size() == 0) chk("char_unexpected", 1, 0);
        else chk("eng_char", int'(eng_char), int'(char_q.pop_front()));
      end
      if (match_vld) begin
        if (match_q.size() == 0) chk("match_unexpected", 1, 0);
        else begin
          match_t m;
          m = match_q.pop_front();
          chk("match_flow", int'(match_flow), int'(m.f));
          chk("match_ofs", int'(match_ofs), int'(m.o));
        end
      end
      if (drop_err) begin
        chk("drop_unexpected", int'(drop_pend == 0), 0);
        if (drop_pend > 0) drop_pend--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [7:0] c, input logic sof, input logic eof,
                         input logic [FW-1:0] f, output int waits);
    logic acc;
    pkt_vld  = 1'b1;
    pkt_char = c;
    pkt_sof  = sof;
    pkt_eof  = eof;
    pkt_flow = sof ? f : FW'($urandom);
    waits = 0;
    while (1) begin
      @(negedge clk);
      acc = pkt_rdy;
      tick();
      if (acc) break;
      waits++;
      if (waits > 20) begin
        chk("handshake_timeout", waits, 0);
        break;
      end
    end
    pkt_vld  = 1'b0;
    pkt_sof  = 1'b0;
    pkt_eof  = 1'b0;
    flow_clr = 1'b0;
  endtask

  function automatic logic [7:0] rbyte(input bit allow_star);
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'h2A) b = 8'h2B;
    if (allow_star && $urandom_range(0, 9) == 0) b = 8'h2A;
    return b;
  endfunction

  task automatic send_pkt(input logic [FW-1:0] f, input logic [7:0] data[$], input bit with_eof,
                          input bit gaps, input bit clr_mid, input int save_clr, output int w0);
    logic [SW-1:0] st;
    logic [FW-1:0] cid;
    int w;
    if (pend_active) begin
      mdl_tbl[pend_flow] = pend_st;
      pend_active = 0;
    end
    st = mdl_tbl[f];
    load_q.push_back(st);
    w0 = 0;
    for (int i = 0; i < data.size(); i++) begin
      if (i > 0 && gaps && $urandom_range(0, 3) == 0) tick();
      if (i > 0 && clr_mid && $urandom_range(0, 3) == 0) begin
        cid = FW'($urandom);
        flow_clr    = 1'b1;
        flow_clr_id = cid;
        mdl_tbl[cid] = '0;
      end
      char_q.push_back(data[i]);
      if (data[i] == 8'h2A) match_q.push_back(match_t'{f, (i > 65535) ? 16'hFFFF : 16'(i)});
      present(data[i], i == 0, with_eof && (i == data.size() - 1), f, w);
      if (i == 0) w0 = w;
      st = eng_step(st, data[i]);
    end
    if (with_eof) begin
      mdl_tbl[f] = st;
      if (save_clr >= 0) begin
        flow_clr    = 1'b1;
        flow_clr_id = FW'(save_clr);
        tick();
        flow_clr = 1'b0;
        mdl_tbl[save_clr] = '0;
      end
    end else begin
      pend_active = 1;
      pend_flow   = f;
      pend_st     = st;
    end
  endtask

  task automatic stray(output int w);
    drop_pend++;
    present(rbyte(1), 1'b0, 1'($urandom_range(0, 1)), '0, w);
  endtask

  function automatic void rand_data(output logic [7:0] d[$], input int len, input bit allow_star);
    d = {};
    for (int i = 0; i < len; i++) d.push_back(rbyte(allow_star));
  endfunction

  initial begin
    logic [7:0] d[$];
    int w, w0, sc;
    rst_n = 1'b0; pkt_vld = 1'b0; pkt_sof = 1'b0; pkt_eof = 1'b0;
    pkt_char = '0; pkt_flow = '0; flow_clr = 1'b0; flow_clr_id = '0;
    for (int i = 0; i < NF; i++) mdl_tbl[i] = '0;
    tick();
    @(negedge clk);
    chk("rst_pkt_rdy", int'(pkt_rdy), 0);
    chk("rst_match_vld", int'(match_vld), 0);
    chk("rst_match_flow", int'(match_flow), 0);
    chk("rst_match_ofs", int'(match_ofs), 0);
    chk("rst_drop_err", int'(drop_err), 0);
    chk("rst_eng_vld", int'(eng_char_vld || eng_state_in_vld), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // flow 3 "ABC", then flow 3 again sees the saved state
    d = {8'h41, 8'h42, 8'h43};
    send_pkt(3, d, 1, 0, 0, -1, w0);
    rand_data(d, 2, 0);
    send_pkt(3, d, 1, 0, 0, -1, w0);

    // match on byte 5 of flow 7
    rand_data(d, 8, 0);
    d[5] = 8'h2A;
    send_pkt(7, d, 1, 1, 0, -1, w0);

    // flow 2, flow 5, flow 2 restores flow 2's state
    rand_data(d, 4, 0); send_pkt(2, d, 1, 0, 0, -1, w0);
    rand_data(d, 3, 0); send_pkt(5, d, 1, 0, 0, -1, w0);
    rand_data(d, 5, 0); send_pkt(2, d, 1, 0, 0, -1, w0);

    // clear of flow 2 colliding with its save; next load must be 0
    rand_data(d, 3, 0); send_pkt(2, d, 1, 0, 0, 2, w0);
    rand_data(d, 2, 0); send_pkt(2, d, 1, 0, 0, -1, w0);

    // single-beat packet timing from IDLE, then a dropped stray beat
    tick(); tick();
    d = {8'h2A};
    send_pkt(9, d, 1, 0, 0, -1, w0);
    chk("single_beat_wait", w0, 2);
    stray(w);
    chk("stray_after_save_wait", w, 1);
    stray(w);

    // reset mid-stream of flow 1 after flow 1 had a saved state
    rand_data(d, 4, 0); send_pkt(1, d, 1, 0, 0, -1, w0);
    rand_data(d, 3, 0); send_pkt(1, d, 0, 0, 0, -1, w0);
    tick();
    rst_n   = 1'b0;
    pkt_vld = 1'b1;
    pkt_sof = 1'b0;
    @(negedge clk);
    chk("rst_mid_pkt_rdy", int'(pkt_rdy), 0);
    chk("rst_mid_eng_vld", int'(eng_char_vld || eng_state_in_vld), 0);
    tick();
    @(negedge clk);
    chk("rst_mid_match_vld", int'(match_vld), 0);
    tick();
    pkt_vld = 1'b0;
    rst_n   = 1'b1;
    for (int i = 0; i < NF; i++) mdl_tbl[i] = '0;
    pend_active = 0;
    load_q = {}; char_q = {}; match_q = {}; drop_pend = 0;
    stray(w);
    chk("post_rst_idle_wait", w, 0);
    rand_data(d, 3, 1); send_pkt(1, d, 1, 0, 0, -1, w0);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      if (!pend_active && $urandom_range(0, 7) == 0) begin
        stray(w);
      end else begin
        bit eof;
        eof = ($urandom_range(0, 4) != 0);
        sc  = (eof && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, NF - 1)) : -1;
        rand_data(d, int'($urandom_range(1, 12)), 1);
        send_pkt(FW'($urandom), d, eof, 1, 1, sc, w0);
      end
    end
    if (pend_active) begin
      rand_data(d, 2, 1);
      send_pkt(FW'($urandom), d, 1, 0, 0, -1, w0);
    end
    repeat (4) tick();
    chk("load_q_drained", load_q.size(), 0);
    chk("char_q_drained", char_q.size(), 0);
    chk("match_q_drained", match_q.size(), 0);
    chk("drop_drained", drop_pend, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dfa_flow_sched.md
DFA_FLOW_SCHED -- requirements
Module: dfa_flow_sched

Interface
REQ-001 Parameter NUM_FLOWS, default 16: number of flow contexts held.
REQ-002 Parameter FLOW_W, default 4: flow id width (log2 NUM_FLOWS).
REQ-003 Parameter STATE_W, default 11: DFA state width.
REQ-004 Port clk  in  1: clock, all logic on rising edge.
REQ-005 Port rst_n  in  1: reset, synchronous, active-low.
REQ-006 Port pkt_vld  in  1: input byte beat valid.
REQ-007 Port pkt_rdy  out  1: beat accepted when pkt_vld & pkt_rdy.
REQ-008 Port pkt_char  in  8: payload byte.
REQ-009 Port pkt_sof  in  1: first byte of packet.
REQ-010 Port pkt_eof  in  1: last byte of packet; may coincide with pkt_sof.
REQ-011 Port pkt_flow  in  FLOW_W: flow id, sampled on sof beat only.
REQ-012 Port eng_char  out  8: byte to DFA engine.
REQ-013 Port eng_char_vld  out  1: engine consumes eng_char this cycle.
REQ-014 Port eng_state_in  out  STATE_W: state to load into engine.
REQ-015 Port eng_state_in_vld  out  1: engine overwrites its state this cycle.
REQ-016 Port eng_state_out  in  STATE_W: engine current state.
REQ-017 Port eng_accept  in  1: engine match flag for current eng_char.
REQ-018 Port flow_clr  in  1: clear one flow context.
REQ-019 Port flow_clr_id  in  FLOW_W: flow to clear.
REQ-020 Port match_vld  out  1: one-cycle match report.
REQ-021 Port match_flow  out  FLOW_W: flow of reported match.
REQ-022 Port match_ofs  out  16: byte offset within packet of matching byte.
REQ-023 Port drop_err  out  1: one-cycle pulse, beat discarded outside a packet.

Function
REQ-024 Context table SHALL hold NUM_FLOWS x STATE_W entries; FSM states IDLE, LOAD, STREAM, SAVE.
REQ-025 IDLE: pkt_rdy=0 if pkt_vld&pkt_sof (latch pkt_flow, go LOAD); else pkt_rdy=1, non-sof beat discarded with drop_err pulse next cycle.
REQ-026 LOAD: eng_state_in=table[flow], eng_state_in_vld=1 for exactly one cycle, pkt_rdy=0, then STREAM.
REQ-027 STREAM: pkt_rdy=1 except per REQ-029; eng_char=pkt_char, eng_char_vld=pkt_vld&pkt_rdy combinationally (zero latency).
REQ-028 STREAM first accepted beat SHALL carry sof; offset counter 0 on it, +1 per accepted beat, saturating at 65535.
REQ-029 STREAM beat with pkt_sof other than the first: pkt_rdy=0, go SAVE (truncated packet); beat held for next LOAD.
REQ-030 Accepted beat with pkt_eof: go SAVE after that edge.
REQ-031 SAVE: table[flow] <= eng_state_out (one cycle, reflects last byte), pkt_rdy=0, then IDLE.
REQ-032 On accepted beat with eng_accept=1: next cycle match_vld=1, match_flow=flow, match_ofs=offset of that beat; else match_vld=0.
REQ-033 Sof+eof single beat: LOAD, STREAM (1 byte), SAVE, IDLE; 4 cycles from first presentation.
REQ-034 flow_clr SHALL write table[flow_clr_id]=0 at the edge; on same-cycle collision with SAVE to same flow, clear wins.
REQ-035 flow_clr to active flow during LOAD/STREAM affects table only; SAVE later overwrites it.
REQ-036 eng_state_in_vld and eng_char_vld SHALL never be 1 in the same cycle.

Reset
REQ-037 rst_n=0: FSM IDLE, all table entries 0, match_vld=0, match_flow=0, match_ofs=0, drop_err=0, eng_*_vld=0.
REQ-038 Reset mid-packet SHALL abandon the packet with no SAVE; pkt_rdy=0 during reset.

Verification
REQ-039 Reset, then flow 3 single packet "ABC" (sof on A, eof on C): one LOAD pulse with eng_state_in=0; 3 eng_char_vld; SAVE writes engine state to table[3].
REQ-040 Engine accept on byte index 5 of flow 7 packet: match_vld one cycle after byte 5 accepted, match_flow=7, match_ofs=5.
REQ-041 Flow 2 packet ends in state S, flow 5 packet, then flow 2 again: second flow 2 LOAD drives eng_state_in=S.
REQ-042 Non-sof beat in IDLE: accepted, no eng_char_vld, drop_err=1 next cycle.
REQ-043 flow_clr id 2 same cycle as SAVE of flow 2: table[2]=0; next flow 2 LOAD drives 0.
REQ-044 rst_n low during STREAM of flow 1 (state S previously saved): table[1]=0 after reset, FSM IDLE, no match_vld.
